// File: rtl/spi_exe_unit_2.sv
// spi_exe_unit_2: SPI-framed execution unit.
// A frame shifts in operand A, operand B and an opcode byte MSB-first, computes
// an M-bit ALU result plus four flags, then shifts {R, F} back out on o_miso.
module spi_exe_unit_2 #(
   parameter int unsigned M   = 8,
   parameter int unsigned OPW = 4
) (
   input  logic i_sclk,
   input  logic i_rst,
   input  logic i_cs,
   input  logic i_mosi,
   output logic o_miso,
   output logic o_valid,
   output logic o_frame_err
);

   localparam int unsigned CW  = $clog2(M + 5) + 1;
   localparam int unsigned SW  = M + 4;
   localparam int unsigned IW  = (M > 8) ? M : 8;
   localparam int unsigned SHW = $clog2(M);

   typedef enum logic [2:0] {
      IDLE,
      LOAD_A,
      LOAD_B,
      LOAD_OP,
      CALC,
      SEND,
      WAIT_CS
   } state_t;

   state_t          r_state;
   logic [CW-1:0]   r_cnt;
   logic [IW-2:0]   r_in_sh;
   logic [M-1:0]    r_a;
   logic [M-1:0]    r_b;
   logic [OPW-1:0]  r_op;
   logic [SW-1:0]   r_out_sh;
   logic            r_miso;
   logic            r_valid;
   logic            r_ferr;

   logic [M-1:0]    w_word;
   logic [OPW-1:0]  w_op_new;
   logic            w_abort;
   logic [7:0]      w_op8;
   logic [SHW-1:0]  w_shamt;
   logic [M-1:0]    w_sum;
   logic [M-1:0]    w_diff;
   logic [M-1:0]    w_res;
   logic            w_of;
   logic            w_bad;
   logic [3:0]      w_flags;

   // Completed-field views of the input shifter including the bit arriving this edge
   always_comb begin
      w_word   = {r_in_sh[M-2:0], i_mosi};
      w_op_new = OPW'({r_in_sh[6:0], i_mosi} >> (8 - OPW));
      w_abort  = i_cs && (r_state inside {LOAD_A, LOAD_B, LOAD_OP, CALC, SEND});
   end

   // ALU: result and flags from the committed operand/opcode registers
   always_comb begin
      w_op8   = 8'(r_op);
      w_shamt = r_b[SHW-1:0];
      w_sum   = r_a + r_b;
      w_diff  = r_a - r_b;
      w_res   = '0;
      w_of    = 1'b0;
      w_bad   = 1'b0;
      case (w_op8)
         8'd0: begin
            w_res = w_sum;
            w_of  = (r_a[M-1] == r_b[M-1]) && (w_sum[M-1] != r_a[M-1]);
         end
         8'd1: begin
            w_res = w_diff;
            w_of  = (r_a[M-1] != r_b[M-1]) && (w_diff[M-1] != r_a[M-1]);
         end
         8'd2:    w_res = r_a & r_b;
         8'd3:    w_res = r_a | r_b;
         8'd4:    w_res = r_a ^ r_b;
         8'd5:    w_res = ~r_a;
         8'd6:    w_res = r_a << w_shamt;
         8'd7:    w_res = r_a >> w_shamt;
         default: w_bad = 1'b1;
      endcase
      w_flags = {w_bad, (w_res == '0), w_of, w_res[M-1]};
   end

   // Frame sequencer: one bit counter, cleared on every state change
   always_ff @(posedge i_sclk or posedge i_rst) begin
      if (i_rst) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_in_sh  <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_op     <= '0;
         r_out_sh <= '0;
         r_miso   <= 1'b0;
         r_valid  <= 1'b0;
         r_ferr   <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         r_cnt   <= r_cnt + CW'(1);
         if (w_abort) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_miso  <= 1'b0;
            r_ferr  <= 1'b1;
         end else begin
            case (r_state)
               IDLE: begin
                  r_cnt <= '0;
                  if (!i_cs) begin
                     r_ferr  <= 1'b0;
                     r_in_sh <= {r_in_sh[IW-3:0], i_mosi};
                     r_state <= LOAD_A;
                  end
               end
               LOAD_A: begin
                  r_in_sh <= {r_in_sh[IW-3:0], i_mosi};
                  if (r_cnt == CW'(M - 2)) begin
                     r_a     <= w_word;
                     r_cnt   <= '0;
                     r_state <= LOAD_B;
                  end
               end
               LOAD_B: begin
                  r_in_sh <= {r_in_sh[IW-3:0], i_mosi};
                  if (r_cnt == CW'(M - 1)) begin
                     r_b     <= w_word;
                     r_cnt   <= '0;
                     r_state <= LOAD_OP;
                  end
               end
               LOAD_OP: begin
                  r_in_sh <= {r_in_sh[IW-3:0], i_mosi};
                  if (r_cnt == CW'(7)) begin
                     r_op    <= w_op_new;
                     r_cnt   <= '0;
                     r_state <= CALC;
                  end
               end
               CALC: begin
                  r_valid  <= 1'b1;
                  r_out_sh <= {w_res, w_flags};
                  r_miso   <= w_res[M-1];
                  r_cnt    <= '0;
                  r_state  <= SEND;
               end
               SEND: begin
                  if (r_cnt == CW'(M + 3)) begin
                     r_miso  <= 1'b0;
                     r_cnt   <= '0;
                     r_state <= WAIT_CS;
                  end else begin
                     r_miso   <= r_out_sh[SW-2];
                     r_out_sh <= r_out_sh << 1;
                  end
               end
               WAIT_CS: begin
                  r_cnt <= '0;
                  if (i_cs) begin
                     r_state <= IDLE;
                  end
               end
               default: begin
                  r_cnt   <= '0;
                  r_miso  <= 1'b0;
                  r_state <= IDLE;
               end
            endcase
         end
      end
   end

   assign o_miso      = r_miso;
   assign o_valid     = r_valid;
   assign o_frame_err = r_ferr;

endmodule

// File: tb/tb_spi_exe_unit_2.sv
// Scoreboard bench for spi_exe_unit_2 (M=8, OPW=4): the driver queues the
// expected {R, F} word and valid edge per frame; the monitor checks each o_valid.
module tb_spi_exe_unit_2;

   localparam int unsigned M = 8;
   localparam int unsigned W = M + 4;

   typedef struct {
      logic [W-1:0] data;
      int           vcyc;
      int           nbits;
   } exp_t;

   exp_t sbq[$];

   logic clk = 1'b0;
   logic rst;
   logic cs;
   logic mosi;
   logic miso;
   logic valid;
   logic ferr;

   int cyc    = 0;
   int n_vec  = 0;
   int n_err  = 0;

   spi_exe_unit_2 #(.M(M), .OPW(4)) dut (
      .i_sclk      (clk),
      .i_rst       (rst),
      .i_cs        (cs),
      .i_mosi      (mosi),
      .o_miso      (miso),
      .o_valid     (valid),
      .o_frame_err (ferr)
   );

   always #5 clk = ~clk;

   // Rising-edge counter used to time o_valid
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, req, cyc);
      end
   endtask

   // Full frame: 3M+13 edges with cs low (+extra WAIT_CS edges), then cs high one edge
   task automatic run_frame(input logic [M-1:0] a, input logic [M-1:0] b,
                            input logic [7:0] opb, input logic [W-1:0] e,
                            input int extra, input logic rel_rst);
      logic [2*M+7:0] bits;
      exp_t x;
      bits = {a, b, opb};
      for (int k = 1; k <= 3*M+13+extra; k++) begin
         @(negedge clk);
         if (k == 1) begin
            if (rel_rst) rst = 1'b0;
            x.data  = e;
            x.vcyc  = cyc + 2*M + 9;
            x.nbits = W;
            sbq.push_back(x);
         end
         cs   = 1'b0;
         mosi = (k <= 2*M+8) ? bits[2*M+8-k] : 1'b0;
         if (k == 2) check("ferr_clear", 32'(ferr), 32'd0);
         if (k > 3*M+13) check("waitcs_miso", 32'(miso), 32'd0);
      end
      @(negedge clk);
      cs   = 1'b1;
      mosi = 1'b0;
      @(negedge clk);
   endtask

   // Monitor: pop on each o_valid, collect the serial word and compare
   initial begin : monitor
      exp_t x;
      logic [W-1:0] got;
      logic [W-1:0] mask;
      forever begin
         @(negedge clk);
         if (valid === 1'b1) begin
            if (sbq.size() == 0) begin
               check("unexpected_valid", 32'(valid), 32'd0);
            end else begin
               x    = sbq.pop_front();
               got  = '0;
               mask = '0;
               check("valid_edge", 32'(cyc), 32'(x.vcyc));
               for (int i = 0; i < x.nbits; i++) begin
                  if (i > 0) @(negedge clk);
                  got[W-1-i]  = miso;
                  mask[W-1-i] = 1'b1;
               end
               check("result_word", 32'(got & mask), 32'(x.data & mask));
               if (x.nbits == W) begin
                  @(negedge clk);
                  check("miso_after_send", 32'(miso), 32'd0);
               end
            end
         end
      end
   end

   initial begin : driver
      logic [2*M+7:0] bits;
      exp_t x;
      rst  = 1'b1;
      cs   = 1'b1;
      mosi = 1'b0;
      #12;
      check("rst_miso", 32'(miso), 32'd0);
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_ferr", 32'(ferr), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Directed ALU frames: {R, F}
      run_frame(8'h7F, 8'h01, 8'h00, 12'h803, 0, 1'b0);  // ADD overflow
      run_frame(8'h05, 8'h05, 8'h10, 12'h004, 0, 1'b0);  // SUB zero
      run_frame(8'h81, 8'h03, 8'h60, 12'h080, 0, 1'b0);  // SHL
      run_frame(8'h81, 8'h03, 8'h70, 12'h100, 0, 1'b0);  // SHR
      run_frame(8'h81, 8'h03, 8'hF0, 12'h00C, 0, 1'b0);  // invalid opcode
      run_frame(8'hF0, 8'h3C, 8'h20, 12'h300, 0, 1'b0);  // AND
      run_frame(8'h80, 8'h01, 8'h30, 12'h811, 0, 1'b0);  // OR
      run_frame(8'hAA, 8'hAA, 8'h40, 12'h004, 0, 1'b0);  // XOR
      run_frame(8'h0F, 8'h00, 8'h50, 12'hF01, 0, 1'b0);  // NOT
      run_frame(8'h80, 8'h01, 8'h10, 12'h7F2, 0, 1'b0);  // SUB overflow
      run_frame(8'h01, 8'h01, 8'h0F, 12'h020, 0, 1'b0);  // low op bits ignored
      run_frame(8'hFF, 8'h01, 8'h00, 12'h004, 0, 1'b0);  // ADD wrap, no overflow
      run_frame(8'h81, 8'h0B, 8'h60, 12'h080, 0, 1'b0);  // shamt uses B[2:0]

      // Abort: cs raised for edge 13
      bits = {8'hA5, 8'h3C, 8'h00};
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         cs   = 1'b0;
         mosi = bits[2*M+8-k];
      end
      @(negedge clk);
      cs = 1'b1;
      @(negedge clk);
      check("abort_ferr", 32'(ferr), 32'd1);
      check("abort_miso", 32'(miso), 32'd0);
      check("abort_valid", 32'(valid), 32'd0);
      repeat (3) @(negedge clk);
      check("ferr_sticky", 32'(ferr), 32'd1);
      run_frame(8'h7F, 8'h01, 8'h00, 12'h803, 0, 1'b0);
      check("ferr_after_frame", 32'(ferr), 32'd0);

      // Hold cs low in WAIT_CS: no second o_valid, miso stays 0
      run_frame(8'h05, 8'h05, 8'h10, 12'h004, 10, 1'b0);

      // Reset mid-SEND: result 0xFF, flags 0001; bits 0..2 seen, then reset after edge 28
      bits = {8'h00, 8'h00, 8'h50};
      for (int k = 1; k <= 2*M+12; k++) begin
         @(negedge clk);
         if (k == 1) begin
            x.data  = 12'hFF1;
            x.vcyc  = cyc + 2*M + 9;
            x.nbits = 3;
            sbq.push_back(x);
         end
         cs   = 1'b0;
         mosi = (k <= 2*M+8) ? bits[2*M+8-k] : 1'b0;
      end
      @(posedge clk);
      #1;
      check("send_miso_before_rst", 32'(miso), 32'd1);
      #1;
      rst = 1'b1;
      #1;
      check("rst_send_miso", 32'(miso), 32'd0);
      check("rst_send_valid", 32'(valid), 32'd0);
      check("rst_send_ferr", 32'(ferr), 32'd0);

      // Release reset with cs low: frame starts on the first edge
      run_frame(8'h40, 8'h40, 8'h00, 12'h803, 0, 1'b1);

      repeat (5) @(negedge clk);
      check("scoreboard_drained", 32'(sbq.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
